ncl_wavefront_ctrl: RTL and testbench

Clocked sequencer that drives one NCL pipeline built from TH22/TH34W22 threshold gates. It converts a synchronous valid/ready word into a dual-rail DATA wavefront and waits for completion. It then captures the result, issues the NULL wavefront, and returns to idle. It sits at the boundary between the clocked system and an asynchronous NCL datapath, owning both the input rails and the output acknowledge.

---
 rtl/ncl_ctrl_pkg.sv | 26 ++
 rtl/ncl_sync.sv | 26 ++
 rtl/ncl_wavefront_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ncl_wavefront_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_ctrl_pkg.sv
// Shared types and encodings for the NCL wavefront controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ncl_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_NULL = 2'd2
    } state_t;

    // Rail pair written as {t, f}
    localparam logic [1:0] RAIL_NULL    = 2'b00;
    localparam logic [1:0] RAIL_DATA0   = 2'b01;
    localparam logic [1:0] RAIL_DATA1   = 2'b10;
    localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

    // Acknowledge polarity, shared by ncl_ko and ncl_ki
    localparam logic ACK_RFD = 1'b1;
    localparam logic ACK_RFN = 1'b0;

    function automatic logic [1:0] rail_pair(input logic t, input logic f);
        return {t, f};
    endfunction

endpackage

// File: rtl/ncl_sync.sv
// Multi-flop synchronizer for an N-bit bus, async reset to 0.
// Latency: STAGES clock cycles.
// Backpressure: none, samples every cycle.
module ncl_sync #(
    parameter int STAGES = 2,
    parameter int N      = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [STAGES-1:0][N-1:0] sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/ncl_wavefront_ctrl.sv
// Clocked sequencer driving DATA/NULL wavefronts into an NCL pipeline; NCL_CTRL_TIMEOUT_EN adds the phase timeout.
// Latency: rails at accept+1; capture SYNC_STAGES+1 cycles after result and ncl_ki settle.
// Backpressure: in_ready drops outside IDLE and while an undrained result blocks the output register.
module ncl_wavefront_ctrl
    import ncl_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] ncl_t,
    output logic [WIDTH-1:0] ncl_f,
    input  logic             ncl_ki,
    input  logic [WIDTH-1:0] ncl_rt,
    input  logic [WIDTH-1:0] ncl_rf,
    output logic             ncl_ko,
    output logic             timeout_err,
    output logic             rail_err
);

    logic             ki_s;
    logic [WIDTH-1:0] rt_s;
    logic [WIDTH-1:0] rf_s;

    ncl_sync #(.STAGES(SYNC_STAGES), .N(1)) u_sync_ki (
        .clk (clk),
        .rst (rst),
        .d   (ncl_ki),
        .q   (ki_s)
    );

    ncl_sync #(.STAGES(SYNC_STAGES), .N(WIDTH)) u_sync_rt (
        .clk (clk),
        .rst (rst),
        .d   (ncl_rt),
        .q   (rt_s)
    );

    ncl_sync #(.STAGES(SYNC_STAGES), .N(WIDTH)) u_sync_rf (
        .clk (clk),
        .rst (rst),
        .d   (ncl_rf),
        .q   (rf_s)
    );

    // An illegal pair is neither complete nor null, so the FSM just keeps waiting.
    logic res_complete;
    logic res_null;
    logic rail_bad;

    always_comb begin
        res_complete = 1'b1;
        res_null     = 1'b1;
        rail_bad     = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            case (rail_pair(rt_s[i], rf_s[i]))
                RAIL_NULL: begin
                    res_complete = 1'b0;
                end
                RAIL_ILLEGAL: begin
                    res_complete = 1'b0;
                    res_null     = 1'b0;
                    rail_bad     = 1'b1;
                end
                default: begin
                    res_null = 1'b0;
                end
            endcase
        end
    end

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] t_d;
    logic [WIDTH-1:0] f_d;
    logic             ko_d;
    logic             ovld_d;
    logic [WIDTH-1:0] odat_d;
    logic             accept;
    logic             capture;
    logic             null_done;

    assign in_ready  = (state_q == ST_IDLE) && (ki_s == ACK_RFD) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign capture   = (state_q == ST_DATA) && res_complete && (ki_s == ACK_RFN);
    assign null_done = (state_q == ST_NULL) && res_null && (ki_s == ACK_RFD);

    always_comb begin
        state_d = state_q;
        t_d     = ncl_t;
        f_d     = ncl_f;
        ko_d    = ncl_ko;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    t_d     = in_data;
                    f_d     = ~in_data;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (capture) begin
                    t_d     = '0;
                    f_d     = '0;
                    ko_d    = ACK_RFN;
                    state_d = ST_NULL;
                end
            end
            ST_NULL: begin
                if (null_done) begin
                    ko_d    = ACK_RFD;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                t_d     = '0;
                f_d     = '0;
                ko_d    = ACK_RFD;
                state_d = ST_IDLE;
            end
        endcase
    end

    // A capture wins over a same-cycle drain so the new result is never lost.
    always_comb begin
        ovld_d = out_valid && !out_ready;
        odat_d = out_data;
        if (capture) begin
            ovld_d = 1'b1;
            odat_d = rt_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ncl_t     <= '0;
            ncl_f     <= '0;
            ncl_ko    <= ACK_RFD;
            out_valid <= 1'b0;
            out_data  <= '0;
            rail_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ncl_t     <= t_d;
            ncl_f     <= f_d;
            ncl_ko    <= ko_d;
            out_valid <= ovld_d;
            out_data  <= odat_d;
            rail_err  <= rail_err || rail_bad;
        end
    end

`ifdef NCL_CTRL_TIMEOUT_EN
    localparam int             TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TO_MAX = TW'(TIMEOUT);

    logic [TW-1:0] to_cnt_q;
    logic [TW-1:0] to_cnt_d;
    logic          to_err_q;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if ((state_q != ST_IDLE) && (to_cnt_q != TO_MAX)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    // Flag is raised on the edge the count reaches TIMEOUT, then the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_q || (to_cnt_d == TO_MAX);
        end
    end

    assign timeout_err = to_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ncl_wavefront_ctrl.sv
// Bench for ncl_wavefront_ctrl: loopback NCL pipeline model, vector table, corner sequences, random traffic vs queue scoreboard.
module tb_ncl_wavefront_ctrl;

    localparam int W = 4;

`ifdef NCL_CTRL_TIMEOUT_EN
    localparam logic EXP_TO = 1'b1;
`else
    localparam logic EXP_TO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic [W-1:0] ncl_t, ncl_f;
    logic         ncl_ki;
    logic [W-1:0] ncl_rt, ncl_rf;
    logic         ncl_ko;
    logic         timeout_err, rail_err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_rx   = 0;

    ncl_wavefront_ctrl #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ncl_t       (ncl_t),
        .ncl_f       (ncl_f),
        .ncl_ki      (ncl_ki),
        .ncl_rt      (ncl_rt),
        .ncl_rf      (ncl_rf),
        .ncl_ko      (ncl_ko),
        .timeout_err (timeout_err),
        .rail_err    (rail_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One-stage loopback pipeline: 3-cycle gate delay into a ko-gated hysteresis register.
    logic [2*W-1:0] dl [3];
    logic [W-1:0]   st_t = '0, st_f = '0;
    logic [W-1:0]   stuck_m = '0, ill_m = '0;
    logic [W-1:0]   mt, mf;

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) dl[i] = '0;
            st_t = '0;
            st_f = '0;
        end else begin
            dl[2] = dl[1];
            dl[1] = dl[0];
            dl[0] = {ncl_t, ncl_f};
            mt = dl[2][2*W-1:W];
            mf = dl[2][W-1:0];
            if (ncl_ko && ((mt ^ mf) == '1)) begin
                st_t = mt;
                st_f = mf;
            end else if (!ncl_ko && ((mt | mf) == '0)) begin
                st_t = '0;
                st_f = '0;
            end
        end
    end

    assign ncl_ki = ((st_t | st_f) == '0);
    assign ncl_rt = (st_t & ~stuck_m) | ill_m;
    assign ncl_rf = (st_f & ~stuck_m) | ill_m;

    // Reference: every accepted word must come out once, unchanged, in order.
    logic [W-1:0] expq [$];

    always @(posedge clk) begin
        if (rst) begin
            expq.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_rx++;
                if (expq.size() == 0) chk("sb_underflow", 32'(expq.size()), 1);
                else chk("sb_order", out_data, expq.pop_front());
            end
            if (in_valid && in_ready) expq.push_back(in_data);
        end
    end

    task automatic send(input logic [W-1:0] d, output int stall, output bit ok);
        stall = 0;
        ok    = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready) begin
            if (stall >= 300) begin
                ok       = 1'b0;
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            stall++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, out_valid, 1);
    endtask

    task automatic wait_ko(input string nm);
        int n = 0;
        while (ncl_ko !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(nm, ncl_ko, 1);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] t;
        logic [W-1:0] f;
        logic [W-1:0] q;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int  st;
        int  stalled;
        int  rx0;
        bit  ok;
        bit  rdone;

        vecs[0] = '{4'hA, 4'b1010, 4'b0101, 4'hA};
        vecs[1] = '{4'h0, 4'b0000, 4'b1111, 4'h0};
        vecs[2] = '{4'hF, 4'b1111, 4'b0000, 4'hF};
        vecs[3] = '{4'h6, 4'b0110, 4'b1001, 4'h6};
        vecs[4] = '{4'h9, 4'b1001, 4'b0110, 4'h9};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ncl_t", ncl_t, 0);
        chk("rst_ncl_f", ncl_f, 0);
        chk("rst_ncl_ko", ncl_ko, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_rail_err", rail_err, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_sync1", in_ready, 0);
        @(negedge clk);
        chk("in_ready_sync2", in_ready, 1);

        // Vector table, fast pipeline
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].d, st, ok);
            chk("tbl_accept", ok, 1);
            chk("tbl_ncl_t", ncl_t, vecs[i].t);
            chk("tbl_ncl_f", ncl_f, vecs[i].f);
            wait_valid("tbl_out_valid");
            chk("tbl_out_data", out_data, vecs[i].q);
            chk("tbl_ko_low", ncl_ko, 0);
            chk("tbl_rails_null", {ncl_t, ncl_f}, 0);
            wait_ko("tbl_ko_high");
        end

        // Back-pressure: only the second word stalls
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        send(4'h3, st, ok);
        chk("bp_w1_stall", st, 0);
        wait_valid("bp_w1_valid");
        wait_ko("bp_w1_ko");
        in_valid = 1'b1;
        in_data  = 4'hC;
        stalled  = 0;
        for (int i = 0; i < 12; i++) begin
            if (!in_ready) stalled++;
            @(negedge clk);
        end
        chk("bp_w2_stalled", stalled, 12);
        chk("bp_hold_data", out_data, 4'h3);
        out_ready = 1'b1;
        #1;
        chk("bp_release", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp_w2_valid");
        wait_ko("bp_w2_ko");
        send(4'h7, st, ok);
        chk("bp_w3_stall", st, 0);
        wait_valid("bp_w3_valid");
        chk("bp_w3_data", out_data, 4'h7);
        wait_ko("bp_w3_ko");
        chk("no_err_timeout", timeout_err, 0);
        chk("no_err_rail", rail_err, 0);

        // Stuck rail: bit 2 never resolves
        stuck_m = 4'b0100;
        send(4'hC, st, ok);
        repeat (9) @(negedge clk);
        chk("to_before_10", timeout_err, 0);
        @(negedge clk);
        chk("to_at_10", timeout_err, EXP_TO);
        repeat (20) @(negedge clk);
        chk("stuck_ko", ncl_ko, 1);
        chk("stuck_no_capture", out_valid, 0);
        chk("stuck_rails_data", ncl_t, 4'hC);
        chk("stuck_in_ready", in_ready, 0);
        stuck_m = '0;
        wait_valid("stuck_recover");
        chk("stuck_data", out_data, 4'hC);
        wait_ko("stuck_ko_back");
        chk("to_sticky", timeout_err, EXP_TO);
        pulse_rst();
        chk("to_cleared", timeout_err, 0);

        // Illegal rail pair on bit 0
        ill_m = 4'b0001;
        send(4'h6, st, ok);
        repeat (20) @(negedge clk);
        chk("ill_rail_err", rail_err, 1);
        chk("ill_no_capture", out_valid, 0);
        ill_m = '0;
        wait_valid("ill_recover");
        chk("ill_data", out_data, 4'h6);
        wait_ko("ill_ko_back");
        chk("ill_sticky", rail_err, 1);
        pulse_rst();
        chk("ill_cleared", rail_err, 0);

        // Reset during DATA
        send(4'h3, st, ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_ncl_t", ncl_t, 0);
        chk("mid_rst_ncl_f", ncl_f, 0);
        chk("mid_rst_ko", ncl_ko, 1);
        chk("mid_rst_in_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(4'h5, st, ok);
        chk("mid_rst_accept", ok, 1);
        wait_valid("mid_rst_valid");
        chk("mid_rst_data", out_data, 4'h5);
        wait_ko("mid_rst_ko_back");

        // Random traffic with random out_ready
        rx0   = n_rx;
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(W'($urandom), st, ok);
                    if (!ok) chk("rnd_accept", ok, 1);
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        @(negedge clk);
        out_ready = 1'b1;
        for (int n = 0; n < 500 && expq.size() != 0; n++) @(negedge clk);
        chk("rnd_drained", 32'(expq.size()), 0);
        chk("rnd_count", n_rx - rx0, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
